// File: rtl/button_debounce.sv
// Push-button conditioner for the 16-bit count stage. It synchronises the raw
// button, filters out contact bounce, and produces a clean debounced level
// plus a single-cycle inc pulse for each accepted press.
module button_debounce #(
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH     = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic inc
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Terminal count of the stability window.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 r_sync_0;
    logic                 r_sync_1;
    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_btn_level;
    logic                 r_inc;
    logic                 w_cnt_done;

    assign w_cnt_done = (r_cnt == CNT_LAST);

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_0 <= 1'b0;
            r_sync_1 <= 1'b0;
        end else begin
            r_sync_0 <= btn_in;
            r_sync_1 <= r_sync_0;
        end
    end

    // Debounce FSM: a new level must hold for STABLE_CYCLES samples; any
    // contrary sample aborts the wait. inc pulses only on an accepted press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_btn_level <= 1'b0;
            r_inc       <= 1'b0;
        end else begin
            r_inc <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_sync_1) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!r_sync_1) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_cnt_done) begin
                        r_state     <= PRESSED;
                        r_btn_level <= 1'b1;
                        r_inc       <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!r_sync_1) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (r_sync_1) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (w_cnt_done) begin
                        r_state     <= IDLE;
                        r_btn_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_btn_level <= 1'b0;
                end
            endcase
        end
    end

    assign btn_level = r_btn_level;
    assign inc       = r_inc;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with STABLE_CYCLES=4: press latency is
// 6 edges from the first edge that samples the new button value.
module tb_button_debounce;

    localparam int unsigned STABLE = 4;

    logic        clk;
    logic        reset;
    logic        btn_in;
    logic        btn_level;
    logic        inc;

    int          n_checks;
    int          n_errors;
    int          pulse_cnt;
    logic [15:0] ds_count;
    logic        inc_prev;

    button_debounce #(
        .STABLE_CYCLES(STABLE),
        .CNT_WIDTH    (20)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .btn_level(btn_level),
        .inc      (inc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and sample 1 time unit later; also models the count stage.
    task automatic tick();
        @(posedge clk);
        #1;
        if (inc) pulse_cnt++;
        if (inc && !inc_prev) ds_count = ds_count + 16'd1;
        inc_prev = inc;
    endtask

    initial begin
        int p0;
        logic [6:0] bounce;
        n_checks  = 0;
        n_errors  = 0;
        pulse_cnt = 0;
        ds_count  = 16'd0;
        inc_prev  = 1'b0;
        bounce    = 7'b0101101; // bit i applied in cycle i: 1,0,1,1,0,1,0

        // Reset values
        reset  = 1'b1;
        btn_in = 1'bx;
        tick();
        check("rst_level0", 32'(btn_level), 0);
        check("rst_inc0", 32'(inc), 0);
        btn_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_level", 32'(btn_level), 0);
            check("rst_inc", 32'(inc), 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_level", 32'(btn_level), 0);
            check("post_rst_inc", 32'(inc), 0);
        end

        // Clean press, held 20 cycles
        p0 = pulse_cnt;
        btn_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("press_level", 32'(btn_level), (i >= 6) ? 1 : 0);
            check("press_inc", 32'(inc), (i == 6) ? 1 : 0);
        end
        check("press_one_pulse", 32'(pulse_cnt - p0), 1);

        // Clean release: level falls 6 edges later, no pulse
        btn_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("release_level", 32'(btn_level), (i < 6) ? 1 : 0);
            check("release_inc", 32'(inc), 0);
        end

        // Bounce then stable 1
        p0 = pulse_cnt;
        for (int i = 0; i < 7; i++) begin
            btn_in = bounce[i];
            tick();
            check("bounce_inc", 32'(inc), 0);
            check("bounce_level", 32'(btn_level), 0);
        end
        check("bounce_no_pulse", 32'(pulse_cnt - p0), 0);
        btn_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("settle_level", 32'(btn_level), (i >= 6) ? 1 : 0);
            check("settle_inc", 32'(inc), (i == 6) ? 1 : 0);
        end

        // Release glitch of 3 cycles while pressed
        p0 = pulse_cnt;
        btn_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("glitch_level", 32'(btn_level), 1);
        end
        btn_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("glitch_hold_level", 32'(btn_level), 1);
            check("glitch_hold_inc", 32'(inc), 0);
        end
        btn_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rel2_level", 32'(btn_level), (i < 6) ? 1 : 0);
            check("rel2_inc", 32'(inc), 0);
        end
        check("glitch_no_pulse", 32'(pulse_cnt - p0), 0);

        // Reset while pressed with button held
        btn_in = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("pre_rst_level", 32'(btn_level), 1);
        reset = 1'b1;
        tick();
        check("midrst_level", 32'(btn_level), 0);
        check("midrst_inc", 32'(inc), 0);
        reset = 1'b0;
        p0 = pulse_cnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rerelease_level", 32'(btn_level), (i >= 6) ? 1 : 0);
            check("rerelease_inc", 32'(inc), (i == 6) ? 1 : 0);
        end
        check("rerelease_one_pulse", 32'(pulse_cnt - p0), 1);

        // Ten clean press/release cycles into the count stage
        btn_in = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("idle_level", 32'(btn_level), 0);
        p0 = pulse_cnt;
        ds_count = 16'd0;
        for (int n = 0; n < 10; n++) begin
            btn_in = 1'b1;
            for (int i = 0; i < 8; i++) tick();
            check("rep_press_level", 32'(btn_level), 1);
            btn_in = 1'b0;
            for (int i = 0; i < 8; i++) tick();
            check("rep_release_level", 32'(btn_level), 0);
        end
        check("rep_pulses", 32'(pulse_cnt - p0), 10);
        check("rep_count", 32'(ds_count), 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
